// File: rtl/i2c_cmd_queue_if.sv
// Command, response and I2C-master-facing signals of i2c_cmd_queue.
// slave: the queue itself; master: the CPU / I2C master side around it.
interface i2c_cmd_queue_if;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_read;
  logic        cmd_ready;
  logic [31:0] m_ctrl_data;
  logic        m_wr_ctrl;
  logic        m_read;
  logic [31:0] m_status;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_ready;

  modport slave (
    input  cmd_valid, cmd_data, cmd_read, m_status, rsp_ready,
    output cmd_ready, m_ctrl_data, m_wr_ctrl, m_read, rsp_valid, rsp_data
  );

  modport master (
    output cmd_valid, cmd_data, cmd_read, m_status, rsp_ready,
    input  cmd_ready, m_ctrl_data, m_wr_ctrl, m_read, rsp_valid, rsp_data
  );
endinterface

// File: rtl/i2c_cmd_queue.sv
// Command/response sequencer in front of the I2C master core.
// Define I2C_CMD_QUEUE_TIMEOUT_EN to add the ACCEPT/RUN watchdog (TIMEOUT_CYCLES).
module i2c_cmd_queue #(
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic           clk,
  input  logic           resetn,
  i2c_cmd_queue_if.slave bus,
  output logic [4:0]     cmd_level,
  output logic [4:0]     rsp_level,
  output logic           engine_busy
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);

  if (CMD_DEPTH < 2 || CMD_DEPTH > 16 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 ||
      RSP_DEPTH < 2 || RSP_DEPTH > 16 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("i2c_cmd_queue: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, ACCEPT, RUN, CAPTURE} state_t;

  state_t state, next_state;
  logic   timeout_expired;
  logic   rsp_timeout;

  // Command FIFO: entry = {read, ctrl word}
  logic [32:0]    cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wr_ptr, cmd_rd_ptr;
  logic [4:0]     cmd_count;
  logic           cmd_push, cmd_pop;
  logic [32:0]    cmd_head;

  assign bus.cmd_ready = (cmd_count != 5'(CMD_DEPTH));
  assign cmd_push      = bus.cmd_valid & bus.cmd_ready;
  assign cmd_pop       = (state == ISSUE);
  assign cmd_head      = cmd_mem[cmd_rd_ptr];

  // NOTE: state uses <= so every flop samples pre-edge values; = here would order-couple the blocks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + 5'd1;
        2'b01:   cmd_count <= cmd_count - 5'd1;
        default: ;
      endcase
    end
  end

  // NOTE: storage arrays are not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr] <= {bus.cmd_read, bus.cmd_data};
  end

  // Response FIFO, first-word fall-through
  logic [31:0]    rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_wr_ptr, rsp_rd_ptr;
  logic [4:0]     rsp_count;
  logic           rsp_push, rsp_pop;

  assign rsp_push      = (state == CAPTURE);
  assign bus.rsp_valid = (rsp_count != 5'd0);
  assign rsp_pop       = bus.rsp_valid & bus.rsp_ready;
  assign bus.rsp_data  = rsp_mem[rsp_rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + 5'd1;
        2'b01:   rsp_count <= rsp_count - 5'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= {rsp_timeout, bus.m_status[30:0]};
  end

  // Sequencer FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // NOTE: next_state is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      // Only one transaction is ever in flight, so a free slot now is a reserved slot.
      IDLE:    if (cmd_count != 5'd0 && rsp_count != 5'(RSP_DEPTH) && !bus.m_status[31])
                 next_state = ISSUE;
      ISSUE:   next_state = ACCEPT;
      ACCEPT:  if (bus.m_status[31])      next_state = RUN;
               else if (timeout_expired)  next_state = CAPTURE;
      RUN:     if (!bus.m_status[31])     next_state = CAPTURE;
               else if (timeout_expired)  next_state = CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Master-facing outputs are flopped from next_state so they align exactly with ISSUE..RUN.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.m_wr_ctrl   <= 1'b0;
      bus.m_read      <= 1'b0;
      bus.m_ctrl_data <= '0;
    end else begin
      bus.m_wr_ctrl <= (next_state == ISSUE);
      if (next_state == ISSUE) begin
        bus.m_ctrl_data <= cmd_head[31:0];
        bus.m_read      <= cmd_head[32];
      end else if (next_state == CAPTURE) begin
        bus.m_read <= 1'b0;
      end
    end
  end

`ifdef I2C_CMD_QUEUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_flag;

  assign timeout_expired = (state == ACCEPT || state == RUN) &&
                           (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout     = tmo_flag;

  // A RUN that ends normally on the expiry cycle is reported as a normal completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else if (state == ISSUE) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else if (state == ACCEPT || state == RUN) begin
      tmo_cnt <= tmo_cnt + 1'b1;
      if (timeout_expired && next_state == CAPTURE && (state == ACCEPT || bus.m_status[31]))
        tmo_flag <= 1'b1;
    end
  end
`else
  assign timeout_expired = 1'b0;
  assign rsp_timeout     = 1'b0;
`endif

  assign cmd_level   = cmd_count;
  assign rsp_level   = rsp_count;
  assign engine_busy = (state != IDLE);
endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Scoreboard bench for i2c_cmd_queue: behavioural I2C master model plus response monitor.
module tb_i2c_cmd_queue;
  localparam int CMD_DEPTH      = 4;
  localparam int RSP_DEPTH      = 4;
  localparam int TIMEOUT_CYCLES = 100;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] cmd_level, rsp_level;
  logic       engine_busy;

  i2c_cmd_queue_if bus ();

  i2c_cmd_queue #(
    .CMD_DEPTH     (CMD_DEPTH),
    .RSP_DEPTH     (RSP_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus.slave),
    .cmd_level  (cmd_level),
    .rsp_level  (rsp_level),
    .engine_busy(engine_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          busy_len;
    logic [31:0] result;
    bit          ignore;
  } plan_t;

  logic [32:0] issue_q[$];
  logic [31:0] rsp_q[$];
  plan_t       plan_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          issued = 0;
  bit          read_bad = 1'b0;
  bit          init_busy = 1'b1;
  bit          hold_busy = 1'b0;
  bit          pop_en = 1'b0;
  int          pop_budget = 0;
  logic [31:0] final_st = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: observed %h, expected condition not reached", name, act);
  endtask

  // I2C master model: goes busy on each wr_ctrl and reports a planned final status.
  initial begin : master_model
    int          busy_left;
    bit          cur_read;
    logic [32:0] exp_cmd;
    plan_t       p;
    busy_left    = 0;
    cur_read     = 1'b0;
    bus.m_status = 32'h8400_0000;
    forever begin
      @(negedge clk);
      if (bus.m_wr_ctrl) begin
        issued++;
        check("issue_while_busy", 32'(bus.m_status[31]), 32'h0);
        if (issue_q.size() == 0) begin
          fail("issue_unexpected", bus.m_ctrl_data);
        end else begin
          exp_cmd = issue_q.pop_front();
          check("m_ctrl_data", bus.m_ctrl_data, exp_cmd[31:0]);
          check("m_read_at_issue", 32'(bus.m_read), 32'(exp_cmd[32]));
          cur_read = exp_cmd[32];
        end
        if (plan_q.size() != 0) begin
          p = plan_q.pop_front();
        end else begin
          p.busy_len   = $urandom_range(2, 10);
          p.result     = $urandom;
          p.result[31] = 1'b0;
          p.result[27] = 1'b0;
          p.ignore     = 1'b0;
        end
        if (p.ignore) begin
          rsp_q.push_back({1'b1, final_st[30:0]});
        end else begin
          rsp_q.push_back({1'b0, p.result[30:0]});
          final_st  = p.result;
          busy_left = p.busy_len;
        end
      end else if (busy_left > 0) begin
        if (bus.m_read !== cur_read) read_bad = 1'b1;
        busy_left--;
        if (busy_left == 0) begin
          check("m_read_held", 32'(read_bad), 32'h0);
          read_bad = 1'b0;
        end
      end else if (!engine_busy && bus.m_read) begin
        read_bad = 1'b1;
      end
      if (busy_left > 0)  bus.m_status = 32'h8000_0000;
      else if (init_busy) bus.m_status = 32'h8400_0000;
      else if (hold_busy) bus.m_status = 32'h8000_0000;
      else                bus.m_status = final_st;
    end
  end

  // Response monitor: compares every popped word against the scoreboard head.
  initial begin : rsp_monitor
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.rsp_ready = pop_en ? ($urandom_range(0, 3) != 0) : (pop_budget > 0);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (rsp_q.size() == 0) fail("rsp_unexpected", bus.rsp_data);
        else                   check("rsp_data", bus.rsp_data, rsp_q.pop_front());
        if (pop_budget > 0) pop_budget--;
      end
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 60000 cycles, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [31:0] d, input logic r);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    bus.cmd_read  = r;
    while (!bus.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) fail("cmd_ready_timeout", 32'(cmd_level));
    else                issue_q.push_back({r, d});
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic try_send(input logic [31:0] d, input logic r, output bit acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    bus.cmd_read  = r;
    acc = bus.cmd_ready;
    if (acc) issue_q.push_back({r, d});
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_level(input logic [4:0] lvl, input int budget, input string name);
    int n = 0;
    while (rsp_level != lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rsp_level != lvl) fail(name, 32'(rsp_level));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    pop_en = 1'b1;
    while ((rsp_q.size() != 0 || issue_q.size() != 0 || rsp_level != 0 ||
            engine_busy || cmd_level != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail("drain_timeout", 32'(rsp_q.size()));
    pop_en = 1'b0;
  endtask

  initial begin : stimulus
    bit acc [5];
    int issued0;
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_read  = 1'b0;
    resetn        = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cmd_ready",   32'(bus.cmd_ready),   32'h1);
    check("rst_rsp_valid",   32'(bus.rsp_valid),   32'h0);
    check("rst_m_wr_ctrl",   32'(bus.m_wr_ctrl),   32'h0);
    check("rst_m_read",      32'(bus.m_read),      32'h0);
    check("rst_m_ctrl_data", bus.m_ctrl_data,      32'h0);
    check("rst_cmd_level",   32'(cmd_level),       32'h0);
    check("rst_rsp_level",   32'(rsp_level),       32'h0);
    check("rst_engine_busy", 32'(engine_busy),     32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Master initialising: the queued write must wait, then run for 20 busy cycles.
    plan_q.push_back('{busy_len: 20, result: 32'h0, ignore: 1'b0});
    send(32'h3A10_0055, 1'b0);
    check("init_cmd_level", 32'(cmd_level), 32'h1);
    repeat (50) @(negedge clk);
    check("init_no_issue", 32'(issued), 32'h0);
    init_busy = 1'b0;
    wait_rsp_level(5'd1, 200, "write_rsp_level");
    check("write_issued",   32'(issued),      32'h1);
    check("write_cmd_lvl",  32'(cmd_level),   32'h0);
    check("write_rsp_lvl",  32'(rsp_level),   32'h1);
    check("write_idle",     32'(engine_busy), 32'h0);

`ifdef I2C_CMD_QUEUE_TIMEOUT_EN
    // Master never goes busy: watchdog must fire after TIMEOUT_CYCLES in ACCEPT.
    plan_q.push_back('{busy_len: 0, result: 32'h0, ignore: 1'b1});
    send(32'h3A20_0000, 1'b0);
    n = 0;
    while (!bus.m_wr_ctrl && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (rsp_level != 5'd2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 32'(n), 32'(TIMEOUT_CYCLES + 2));
    check("timeout_idle",    32'(engine_busy), 32'h0);
`endif
    drain(2000);

    // Read transaction returning data.
    plan_q.push_back('{busy_len: 8, result: 32'h1000_00A5, ignore: 1'b0});
    send(32'h3A11_0000, 1'b1);
    drain(2000);

    // Master held busy: fifth command is dropped, four issue in order afterwards.
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) try_send($urandom, 1'($urandom_range(0, 1)), acc[i]);
    for (int i = 0; i < 4; i++) check("full_accept", 32'(acc[i]), 32'h1);
    check("full_drop",      32'(acc[4]),    32'h0);
    check("full_cmd_level", 32'(cmd_level), 32'h4);
    check("full_ready",     32'(bus.cmd_ready), 32'h0);
    hold_busy = 1'b0;
    drain(3000);

    // Response FIFO never popped: exactly RSP_DEPTH transactions run, then one pop frees one more.
    issued0 = issued;
    for (int i = 0; i < 6; i++) send($urandom, 1'($urandom_range(0, 1)));
    wait_rsp_level(5'(RSP_DEPTH), 1000, "rspfull_level");
    repeat (30) @(negedge clk);
    check("rspfull_issued",    32'(issued - issued0), 32'(RSP_DEPTH));
    check("rspfull_idle",      32'(engine_busy),      32'h0);
    check("rspfull_cmd_level", 32'(cmd_level),        32'h2);
    pop_budget = 1;
    n = 0;
    while (issued - issued0 != RSP_DEPTH + 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rspfull_pop_issue", 32'(issued - issued0), 32'(RSP_DEPTH + 1));
    drain(3000);

    // Random traffic with random response back-pressure.
    pop_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send($urandom, 1'($urandom_range(0, 1)));
    end
    drain(20000);

    repeat (5) @(negedge clk);
    check("final_m_read_idle", 32'(read_bad),       32'h0);
    check("final_issue_q",     32'(issue_q.size()), 32'h0);
    check("final_rsp_q",       32'(rsp_q.size()),   32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/i2c_cmd_queue.md
Name: i2c_cmd_queue

Overview:
- Command sequencer directly upstream of the I2C master core.
- Buffers CPU-issued I2C transaction words in a command FIFO and presents them to the master's ctrl_data/wr_ctrl/read inputs one at a time, only when the master is idle.
- Waits for each transaction to complete and pushes the master's final status word into a response FIFO for the CPU to read back.
- Removes busy polling and overrun risk from software.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of two, 2..16).
- RSP_DEPTH, 4, response FIFO entries (power of two, 2..16).
- TIMEOUT_CYCLES, 65535, watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  upstream command strobe.
- cmd_data  in  32  I2C control word, passed to the master unchanged.
- cmd_read  in  1  1 = read transaction, 0 = write.
- cmd_ready  out  1  command FIFO not full.
- m_ctrl_data  out  32  to master ctrl_data.
- m_wr_ctrl  out  1  to master wr_ctrl; single-cycle pulse.
- m_read  out  1  to master read; held for the whole transaction.
- m_status  in  32  from master status (bit31 busy, 30 addr NACK, 29 data NACK, 28 read valid, 27 overrun, 26 init, 7:0 data).
- rsp_valid  out  1  response FIFO not empty.
- rsp_data  out  32  head response word.
- rsp_ready  in  1  pop response.
- cmd_level  out  5  command FIFO occupancy.
- rsp_level  out  5  response FIFO occupancy.
- engine_busy  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset: single clock. Reset is asynchronous, active-low, on resetn.
- Reset values:
  - Both FIFOs empty.
  - cmd_ready=1, rsp_valid=0.
  - m_wr_ctrl=0, m_read=0, m_ctrl_data=0.
  - levels=0, engine_busy=0, FSM=IDLE.
- Command FIFO:
  - A write occurs on the cycle cmd_valid & cmd_ready; it stores {cmd_read, cmd_data}.
  - cmd_valid while full is dropped; cmd_ready=0 in that case.
  - Pointers wrap modulo CMD_DEPTH.
  - cmd_ready is combinational from occupancy.
- Response FIFO:
  - rsp_data/rsp_valid are first-word fall-through.
  - A pop occurs on rsp_valid & rsp_ready; a pop when empty is ignored.
- Simultaneous push and pop on either FIFO, including at full or empty, leaves the level unchanged and is legal.
- FSM states:
  - IDLE:
    - Leaves for ISSUE when all three hold: command FIFO not empty, response FIFO has at least one free slot (counting entries already committed), and m_status[31]==0.
    - The m_status[31]==0 check holds off issue while the master is still initialising after reset.
  - ISSUE (1 cycle):
    - Pops the head command.
    - Drives m_ctrl_data=cmd_data, m_read=cmd_read, m_wr_ctrl=1 (registered, so the pulse is exactly one cycle).
    - Goes to ACCEPT.
  - ACCEPT:
    - m_wr_ctrl=0; m_read held.
    - Waits for m_status[31]==1, then goes to RUN.
  - RUN:
    - m_read held.
    - Waits for m_status[31]==0, then goes to CAPTURE.
  - CAPTURE (1 cycle):
    - Pushes rsp_data = {1'b0 (timeout flag), m_status[30:0]}.
    - Clears m_read to 0.
    - Goes to IDLE.
- m_ctrl_data keeps its last value outside ISSUE.
- Minimum issue-to-issue spacing is 4 cycles plus the master's busy time.
- Every command produces exactly one response, in command order.
- Slot reservation: a command is never issued without a guaranteed response slot, so the response FIFO never overflows. A full response FIFO stalls the engine in IDLE until the CPU pops.
- The engine never pulses m_wr_ctrl while m_status[31]=1, so master overrun (bit27) must never be set by this block.
- Reset mid-transaction: all state clears immediately. Resetn is shared with the master, so both restart together.

Optional Feature:
- Macro: I2C_CMD_QUEUE_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCEPT and RUN, cleared on entry to ACCEPT.
  - If it reaches TIMEOUT_CYCLES, the FSM goes to CAPTURE and pushes a response with bit31=1 and bits 30:0 = m_status[30:0] at that cycle.
  - The FSM then returns to IDLE; IDLE still requires m_status[31]==0 before the next issue.
- Not defined:
  - No counter is present; ACCEPT and RUN wait indefinitely.
  - Response bit31 is always 0.

Test Plan:
- Reset then master init: hold m_status=32'h84000000 for 50 cycles with one command queued -> no m_wr_ctrl. Drive m_status=0 -> one-cycle m_wr_ctrl with m_ctrl_data equal to the command.
- Write command 32'h3A100055, slave model busy for 20 cycles, final status 32'h0 -> m_read=0 throughout; one response 32'h00000000; cmd_level 1->0; rsp_level 0->1.
- Read command cmd_read=1, slave returns status 32'h100000A5 -> m_read=1 from ISSUE through RUN; response 32'h100000A5.
- Push 5 commands with CMD_DEPTH=4 and the master held busy -> 5th dropped while cmd_ready=0. The 4 queued commands issue in order with no bit27 ever set by the model.
- RSP_DEPTH=4 and never pop -> exactly 4 transactions run, engine stays in IDLE with 0 commands issued while the response FIFO is full. One pop -> the next command issues.
- With I2C_CMD_QUEUE_TIMEOUT_EN and TIMEOUT_CYCLES=100, master never raises busy -> response 32'h80000000 after 100 cycles in ACCEPT; FSM returns to IDLE.
